// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Sequential read-out engine for a processor register file.
//               Walks an index range (modulo N), drives the register file
//               read-select, captures the combinational read data and streams
//               each word out over a valid/ready handshake.
// Ports       :
//   clk              - system clock, rising edge
//   reset            - asynchronous active-low reset
//   start            - one-cycle dump request, sampled only when idle
//   abort            - synchronous cancel of a dump in progress
//   first_reg        - first index of the range, latched on accepted start
//   last_reg         - last index of the range (inclusive), latched on start
//   rf_read_register - read-select to the register file port
//   rf_read_data     - combinational read data for rf_read_register
//   dump_data        - captured register word
//   dump_index       - index of dump_data
//   dump_last        - final word of the range
//   dump_valid       - stream word valid
//   dump_ready       - consumer ready
//   busy             - high from accepted start until return to idle
//   done             - one-cycle pulse after the last word is accepted
//   err              - one-cycle pulse when a start is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int WORD_LENGTH = 32,
    parameter int N           = 32,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  first_reg,
    input  logic [ADDR_WIDTH-1:0]  last_reg,
    output logic [ADDR_WIDTH-1:0]  rf_read_register,
    input  logic [WORD_LENGTH-1:0] rf_read_data,
    output logic [WORD_LENGTH-1:0] dump_data,
    output logic [ADDR_WIDTH-1:0]  dump_index,
    output logic                   dump_last,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Range check is done one bit wider so that N == 2**ADDR_WIDTH works.
    localparam logic [ADDR_WIDTH:0]   c_num_regs = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH-1:0] c_max_idx  = ADDR_WIDTH'(N - 1);

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic [ADDR_WIDTH-1:0]  r_last_reg;
    logic [WORD_LENGTH-1:0] r_dump_data;
    logic [ADDR_WIDTH-1:0]  r_dump_index;
    logic                   r_dump_last;
    logic                   r_dump_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                   w_range_ok;
    logic [ADDR_WIDTH-1:0]  w_next_idx;

    assign w_range_ok = ({1'b0, first_reg} < c_num_regs) &&
                        ({1'b0, last_reg}  < c_num_regs);

    // Increment modulo N so a first > last range wraps through N-1 to 0.
    assign w_next_idx = (r_idx == c_max_idx) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_last_reg   <= '0;
            r_dump_data  <= '0;
            r_dump_index <= '0;
            r_dump_last  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Abort is meaningless here, so start always takes priority.
                    if (start) begin
                        if (w_range_ok) begin
                            r_idx      <= first_reg;
                            r_last_reg <= last_reg;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (abort) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        // Capture on this edge: a write committing on the same
                        // edge is not visible, the old content is taken.
                        r_dump_data  <= rf_read_data;
                        r_dump_index <= r_idx;
                        r_dump_last  <= (r_idx == r_last_reg);
                        r_dump_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end
                end

                S_OUT: begin
                    // Abort beats a simultaneous handshake; the word is dropped.
                    if (abort) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_dump_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        r_dump_last <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rf_read_register = r_idx;
    assign dump_data        = r_dump_data;
    assign dump_index       = r_dump_index;
    assign dump_last        = r_dump_last;
    assign dump_valid       = r_dump_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Self-checking bench for regfile_dump_reader. A behavioural
//               register file answers reads; expected streams are derived
//               from the range rule (first..last modulo N) over a snapshot of
//               the register contents taken at start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int WL = 32;
    localparam int NR = 32;
    localparam int AW = 6;   // one spare bit so out-of-range indices can be driven

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic [AW-1:0] rf_read_register;
    logic [WL-1:0] rf_read_data;
    logic [WL-1:0] dump_data;
    logic [AW-1:0] dump_index;
    logic          dump_last;
    logic          dump_valid;
    logic          dump_ready;
    logic          busy;
    logic          done;
    logic          err;

    // Behavioural register file: synchronous write, combinational read.
    logic [WL-1:0] rf [NR];
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [WL-1:0] wr_data;

    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
    assign rf_read_data = rf[rf_read_register[4:0]];

    int vectors = 0;
    int errors  = 0;

    regfile_dump_reader #(
        .WORD_LENGTH (WL),
        .N           (NR),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .first_reg        (first_reg),
        .last_reg         (last_reg),
        .rf_read_register (rf_read_register),
        .rf_read_data     (rf_read_data),
        .dump_data        (dump_data),
        .dump_index       (dump_index),
        .dump_last        (dump_last),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [WL-1:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rfsel"}, 32'(rf_read_register), 0);
        chk({tag, "_data"},  dump_data,             0);
        chk({tag, "_index"}, 32'(dump_index),       0);
        chk({tag, "_ctl"},   {27'd0, dump_valid, dump_last, busy, done, err}, 0);
    endtask

    // Complete dump of [f..l] modulo NR. Word number stall_k has dump_ready
    // held low for stall_n valid cycles; otherwise ready is random with
    // stall_pct percent of low cycles.
    task automatic do_dump(input int f, input int l, input int stall_pct,
                           input int stall_k, input int stall_n, input string tag);
        int            exp_idx[$];
        logic [WL-1:0] snap [NR];
        int            i, k, cyc, held, first_v;
        logic          pv, pr;
        logic [WL-1:0] pd;
        logic [AW-1:0] pi;

        i = f;
        forever begin
            exp_idx.push_back(i);
            if (i == l) break;
            i = (i + 1) % NR;
        end
        for (int j = 0; j < NR; j++) snap[j] = rf[j];

        start = 1'b1; first_reg = AW'(f); last_reg = AW'(l); dump_ready = 1'b0;
        step();
        start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 1);

        k = 0; cyc = 0; held = 0; first_v = -1; pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
        while (k < exp_idx.size() && cyc < 1000) begin
            if (dump_valid && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                chk({tag, "_hold_valid"}, 32'(dump_valid), 1);
                chk({tag, "_hold_data"},  dump_data, pd);
                chk({tag, "_hold_index"}, 32'(dump_index), 32'(pi));
            end
            if (k == stall_k && held < stall_n) begin
                dump_ready = 1'b0;
                if (dump_valid) held++;
            end else begin
                dump_ready = ($urandom_range(99) >= stall_pct);
            end
            if (dump_valid && dump_ready) begin
                chk({tag, "_index"}, 32'(dump_index), exp_idx[k]);
                chk({tag, "_data"},  dump_data, snap[exp_idx[k]]);
                chk({tag, "_last"},  32'(dump_last), (k == exp_idx.size() - 1) ? 1 : 0);
                chk({tag, "_done_early"}, 32'(done), 0);
                k++;
            end
            pv = dump_valid; pr = dump_ready; pd = dump_data; pi = dump_index;
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        chk({tag, "_word_count"}, k, exp_idx.size());
        chk({tag, "_first_latency"}, first_v, 1);
        if (stall_n > 0) chk({tag, "_stall_len"}, held, stall_n);
        // One cycle after the final handshake: done pulses, busy drops.
        chk({tag, "_valid_after"}, 32'(dump_valid), 0);
        chk({tag, "_done_wait"}, 32'(done), 0);
        step();
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; first_reg = '0; last_reg = '0;
        dump_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk); @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        for (int j = 0; j < NR; j++) wr(j, 32'h1000 + j);

        // Basic range, always ready.
        do_dump(3, 5, 0, -1, 0, "basic");
        // Wrap-around through N-1.
        do_dump(30, 1, 0, -1, 0, "wrap");
        // Backpressure on the second word.
        do_dump(8, 11, 0, 1, 5, "bp");
        // Single word and full range.
        do_dump(17, 17, 0, -1, 0, "single");
        do_dump(5, 4, 20, -1, 0, "full");

        // Coherency: r4 written on its fetch edge (old value seen),
        // r5 written one cycle before its fetch edge (new value seen).
        start = 1'b1; first_reg = 6'd4; last_reg = 6'd5; dump_ready = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hDEADBEEF;
        step();
        chk("coh_valid4", 32'(dump_valid), 1);
        chk("coh_data4",  dump_data, 32'h1004);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        chk("coh_fetch5", 32'(dump_valid), 0);
        step();
        chk("coh_data5",  dump_data, 32'hDEADBEEF);
        chk("coh_index5", 32'(dump_index), 5);
        chk("coh_last5",  32'(dump_last), 1);
        step();
        dump_ready = 1'b0;
        step();
        chk("coh_done", 32'(done), 1);
        step();

        // Abort in OUT together with a handshake.
        start = 1'b1; first_reg = 6'd0; last_reg = 6'd7; dump_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("abort_pre_valid", 32'(dump_valid), 1);
        abort = 1'b1; dump_ready = 1'b1;
        step();
        abort = 1'b0; dump_ready = 1'b0;
        chk("abort_valid", 32'(dump_valid), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_done",  32'(done), 0);
        step();
        chk("abort_done2", 32'(done), 0);
        do_dump(2, 2, 0, -1, 0, "post_abort");

        // Rejected start: last_reg == N.
        start = 1'b1; first_reg = 6'd0; last_reg = 6'(NR);
        step();
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_busy",  32'(busy), 0);
        step();
        chk("err_clear", 32'(err), 0);
        chk("err_idle_valid", 32'(dump_valid), 0);

        // Randomized dumps with register content refreshed between runs.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 4; j++) wr($urandom_range(NR - 1), $urandom);
            do_dump($urandom_range(NR - 1), $urandom_range(NR - 1), 35, -1, 0, "rand");
        end

        // Asynchronous reset in the middle of a dump.
        start = 1'b1; first_reg = 6'd9; last_reg = 6'd20;
        step();
        start = 1'b0;
        step();
        chk("mid_valid", 32'(dump_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_reset_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
